image_frame_scheduler: RTL

//  Sequences draining of NUM_CH image-buffer FIFOs into one framed byte stream for the UART transmitter.

---
 rtl/image_frame_scheduler_pkg.sv | 18 +
 rtl/image_frame_scheduler_if.sv | 23 ++
 rtl/image_frame_scheduler_frame_byte_sel.sv | 65 ++++++
 rtl/image_frame_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/image_frame_scheduler_pkg.sv
// Shared types and constants for the image frame scheduler.
// Build option: IMAGE_FRAME_CSUM_EN enables the trailing checksum byte.
package image_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_CAP  = 3'd2,
        S_HDR  = 3'd3,
        S_SEQ  = 3'd4,
        S_DATA = 3'd5,
        S_CSUM = 3'd6,
        S_END  = 3'd7
    } state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

endpackage

// File: rtl/image_frame_scheduler_if.sv
// FIFO read ports and transmitter byte-load handshake seen by the scheduler.
// master = scheduler side, slave = FIFO bank / UART side.
interface image_frame_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int WORD_W = 16
);
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH-1:0]        fifo_rd;
    logic [NUM_CH*WORD_W-1:0] fifo_data;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;

    modport master (
        input  fifo_empty, fifo_data, tx_ready,
        output fifo_rd, tx_data, tx_valid
    );

    modport slave (
        output fifo_empty, fifo_data, tx_ready,
        input  fifo_rd, tx_data, tx_valid
    );
endinterface

// File: rtl/image_frame_scheduler_frame_byte_sel.sv
// Capture-register bank for one popped word per channel, the (ch, byte)
// output mux, and the lowest/next-enabled channel search used to walk a frame.
module frame_byte_sel #(
    parameter int NUM_CH = 4,
    parameter int WORD_W = 16,
    parameter int CH_W   = 2,
    parameter int BYTE_W = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cap_i,
    input  logic [NUM_CH-1:0]        en_i,
    input  logic [NUM_CH*WORD_W-1:0] data_i,
    input  logic [CH_W-1:0]          ch_i,
    input  logic [BYTE_W-1:0]        byte_i,
    output logic [7:0]               byte_o,
    output logic [CH_W-1:0]          first_ch_o,
    output logic [CH_W-1:0]          next_ch_o,
    output logic                     next_vld_o
);
    localparam int BPW = WORD_W / 8;

    logic [WORD_W-1:0] cap_q [NUM_CH];
    logic [WORD_W-1:0] word_sel;

    // Latch the words of enabled channels the cycle after the FIFO pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) cap_q[c] <= '0;
        end else if (cap_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (en_i[c]) cap_q[c] <= data_i[c*WORD_W +: WORD_W];
            end
        end
    end

    // Select the current channel word, then the current byte lane (LSB first)
    always_comb begin
        word_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_i == CH_W'(c)) word_sel = cap_q[c];
        end
        byte_o = 8'h00;
        for (int b = 0; b < BPW; b++) begin
            if (byte_i == BYTE_W'(b)) byte_o = word_sel[b*8 +: 8];
        end
    end

    // Priority search from the top down so the lowest qualifying index wins
    always_comb begin
        first_ch_o = '0;
        next_ch_o  = '0;
        next_vld_o = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (en_i[c]) begin
                first_ch_o = CH_W'(c);
                if (CH_W'(c) > ch_i) begin
                    next_ch_o  = CH_W'(c);
                    next_vld_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/image_frame_scheduler.sv
// Drains NUM_CH image-buffer FIFOs into one framed byte stream for the UART:
// header, sequence, enabled channel words LSB-first, optional checksum.
// Build option: IMAGE_FRAME_CSUM_EN appends the two's-complement checksum byte.
//
// state  | meaning
// S_IDLE | stopped; tracking ch_en, waiting for run
// S_WAIT | waiting until every enabled FIFO holds a word; pops them together
// S_CAP  | popped words arrive and are captured
// S_HDR  | presenting header byte
// S_SEQ  | presenting sequence byte (last completed + 1)
// S_DATA | walking enabled channels, one byte per handshake
// S_CSUM | presenting checksum byte (checksum builds only)
// S_END  | frame complete; bump seq_num, loop or stop
module image_frame_scheduler
    import image_frame_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter int         WORD_W   = 16,
    parameter logic [7:0] HDR_BYTE = HDR_DEFAULT
) (
    input  logic                    clk40M_i,
    input  logic                    rst_i,
    input  logic                    run_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    image_frame_scheduler_if.master bus,
    output logic                    busy_o,
    output logic [7:0]              seq_num_o
);
    localparam int BPW    = WORD_W / 8;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [7:0]        seq_q, seq_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
`ifdef IMAGE_FRAME_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              hs;
    logic              wait_ok;
    logic              last_byte;
    logic              cap;
    logic [7:0]        sel_byte;
    logic [CH_W-1:0]   first_ch;
    logic [CH_W-1:0]   next_ch;
    logic              next_vld;

    // An all-zero mask must never qualify, otherwise an empty frame would go out
    assign wait_ok   = (en_q != '0) && ((~bus.fifo_empty & en_q) == en_q);
    assign hs        = bus.tx_valid & bus.tx_ready;
    assign last_byte = (byte_q == BYTE_W'(BPW - 1));
    assign cap       = (state_q == S_CAP);
    assign busy_o    = (state_q != S_IDLE);
    assign seq_num_o = seq_q;
    assign bus.fifo_rd = (state_q == S_WAIT && run_i && wait_ok) ? en_q : '0;

    frame_byte_sel #(
        .NUM_CH (NUM_CH),
        .WORD_W (WORD_W),
        .CH_W   (CH_W),
        .BYTE_W (BYTE_W)
    ) u_sel (
        .clk_i      (clk40M_i),
        .rst_i      (rst_i),
        .cap_i      (cap),
        .en_i       (en_q),
        .data_i     (bus.fifo_data),
        .ch_i       (ch_q),
        .byte_i     (byte_q),
        .byte_o     (sel_byte),
        .first_ch_o (first_ch),
        .next_ch_o  (next_ch),
        .next_vld_o (next_vld)
    );

    // Byte lane is a pure decode of state so it holds steady until accepted
    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        case (state_q)
            S_HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = HDR_BYTE;
            end
            S_SEQ: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = seq_q + 8'd1;
            end
            S_DATA: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = sel_byte;
            end
`ifdef IMAGE_FRAME_CSUM_EN
            S_CSUM: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = (~csum_q) + 8'd1;
            end
`endif
            default: ;
        endcase
    end

    // Frame sequencing; ch_en is tracked in IDLE/WAIT and on the END->WAIT edge
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        seq_d   = seq_q;
        ch_d    = ch_q;
        byte_d  = byte_q;
`ifdef IMAGE_FRAME_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                en_d = ch_en_i;
                if (run_i && ch_en_i != '0) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!run_i) begin
                    state_d = S_IDLE;
                end else if (wait_ok) begin
                    state_d = S_CAP;
                end else begin
                    en_d = ch_en_i;
                end
            end
            S_CAP: begin
                state_d = S_HDR;
`ifdef IMAGE_FRAME_CSUM_EN
                csum_d  = 8'h00;
`endif
            end
            S_HDR: begin
                if (hs) state_d = S_SEQ;
            end
            S_SEQ: begin
                if (hs) begin
                    state_d = S_DATA;
                    ch_d    = first_ch;
                    byte_d  = '0;
`ifdef IMAGE_FRAME_CSUM_EN
                    csum_d  = csum_q + bus.tx_data;
`endif
                end
            end
            S_DATA: begin
                if (hs) begin
`ifdef IMAGE_FRAME_CSUM_EN
                    csum_d = csum_q + bus.tx_data;
`endif
                    if (!last_byte) begin
                        byte_d = byte_q + 1'b1;
                    end else if (next_vld) begin
                        ch_d   = next_ch;
                        byte_d = '0;
                    end else begin
`ifdef IMAGE_FRAME_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_END;
`endif
                    end
                end
            end
`ifdef IMAGE_FRAME_CSUM_EN
            S_CSUM: begin
                if (hs) state_d = S_END;
            end
`endif
            S_END: begin
                seq_d = seq_q + 8'd1;
                if (run_i) begin
                    state_d = S_WAIT;
                    en_d    = ch_en_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any partially sent frame
    always_ff @(posedge clk40M_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            seq_q   <= 8'h00;
            ch_q    <= '0;
            byte_q  <= '0;
`ifdef IMAGE_FRAME_CSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            seq_q   <= seq_d;
            ch_q    <= ch_d;
            byte_q  <= byte_d;
`ifdef IMAGE_FRAME_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
